// File: rtl/step_dir_decoder.sv
// Step/direction input decoder: synchronizes and glitch-filters step/dir/enable,
// keeps a signed position, measures step period and flags stalls and reversals.
module step_dir_decoder #(
  parameter int MIN_PULSE      = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int POS_WIDTH      = 24,
  parameter int PERIOD_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    enable_n_in,
  input  logic                    pos_clear,
  input  logic                    pos_load,
  input  logic [POS_WIDTH-1:0]    pos_load_val,
  output logic [POS_WIDTH-1:0]    position,
  output logic                    step_valid,
  output logic                    step_dir,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    moving,
  output logic                    stall,
  output logic                    dir_flip,
  output logic [1:0]              dbg_state
);

  localparam int FCNT_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(MIN_PULSE - 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  // Gap counter must reach the timeout even when that exceeds the period width.
  localparam int GAP_W  = (TO_W > PERIOD_WIDTH) ? TO_W : PERIOD_WIDTH;
  localparam logic [GAP_W-1:0] GAP_MAX     = '1;
  localparam logic [GAP_W-1:0] GAP_TIMEOUT = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W:0]   PER_MAX     = (GAP_W + 1)'((64'd1 << PERIOD_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_MOVING = 2'd2
  } state_t;

  logic              r_step_s1, r_step_s2, r_dir_s1, r_dir_s2, r_en_s1, r_en_s2;
  logic              r_filt, r_filt_d, r_event, r_seen_low, r_have_dir;
  logic [1:0]        r_fill;
  logic [FCNT_W-1:0] r_fcnt;
  logic [GAP_W-1:0]  r_gap;
  logic [POS_WIDTH-1:0]    r_pos;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic              r_step_valid, r_step_dir, r_period_valid, r_dir_flip;
  state_t            r_state, w_next;
  logic              w_rise, w_step, w_timeout;
  logic [GAP_W:0]    w_gap_inc;
  logic [PERIOD_WIDTH-1:0] w_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s1 <= 1'b0; r_step_s2 <= 1'b0;
      r_dir_s1  <= 1'b0; r_dir_s2  <= 1'b0;
      r_en_s1   <= 1'b0; r_en_s2   <= 1'b0;
    end else begin
      r_step_s1 <= step_in;     r_step_s2 <= r_step_s1;
      r_dir_s1  <= dir_in;      r_dir_s2  <= r_dir_s1;
      r_en_s1   <= enable_n_in; r_en_s2   <= r_en_s1;
    end
  end

  // Glitch filter; r_fill marks when the synchronizer holds real samples so a
  // line already high at reset release is not mistaken for a fresh step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt     <= 1'b0;
      r_filt_d   <= 1'b0;
      r_fcnt     <= '0;
      r_fill     <= 2'b00;
      r_seen_low <= 1'b0;
      r_event    <= 1'b0;
    end else begin
      r_filt_d   <= r_filt;
      r_fill     <= {r_fill[0], 1'b1};
      r_seen_low <= r_seen_low | (r_fill[1] & ~r_step_s2);
      r_event    <= w_rise & ~r_en_s2 & r_seen_low;
      if (r_step_s2 != r_filt) begin
        if (r_fcnt == FCNT_LAST) begin
          r_filt <= r_step_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FCNT_W'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_rise    = r_filt & ~r_filt_d;
  assign w_step    = r_event & ~r_en_s2;
  assign w_gap_inc = {1'b0, r_gap} + (GAP_W + 1)'(1);
  assign w_period  = (w_gap_inc > PER_MAX) ? '1 : w_gap_inc[PERIOD_WIDTH-1:0];
  assign w_timeout = (r_state == S_MOVING) && !w_step && !r_en_s2 && (r_gap >= GAP_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if (w_step) begin
      r_gap <= '0;
    end else if (r_gap != GAP_MAX) begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!r_en_s2) w_next = w_step ? S_MOVING : S_ARMED;
      S_ARMED:  if (w_step) w_next = S_MOVING;
      S_MOVING: if (w_timeout) w_next = S_ARMED;
      default:  w_next = S_IDLE;
    endcase
    if (r_en_s2) w_next = S_IDLE;
  end

  always_comb begin
    moving    = (r_state == S_MOVING);
    stall     = w_timeout;
    dbg_state = r_state;
  end

  // Strobes outrank the step for the position, but the step is still reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos          <= '0;
      r_period       <= '0;
      r_step_valid   <= 1'b0;
      r_step_dir     <= 1'b0;
      r_period_valid <= 1'b0;
      r_dir_flip     <= 1'b0;
      r_have_dir     <= 1'b0;
    end else begin
      r_step_valid   <= w_step;
      r_period_valid <= w_step && (r_state == S_MOVING);
      r_dir_flip     <= w_step && r_have_dir && (r_dir_s2 != r_step_dir);
      if (w_step) begin
        r_step_dir <= r_dir_s2;
        r_have_dir <= 1'b1;
        if (r_state == S_MOVING) r_period <= w_period;
      end else if (r_state == S_IDLE) begin
        r_have_dir <= 1'b0;
      end
      if (pos_clear)     r_pos <= '0;
      else if (pos_load) r_pos <= pos_load_val;
      else if (w_step)   r_pos <= r_dir_s2 ? r_pos - POS_WIDTH'(1) : r_pos + POS_WIDTH'(1);
    end
  end

  assign position     = r_pos;
  assign period       = r_period;
  assign step_valid   = r_step_valid;
  assign step_dir     = r_step_dir;
  assign period_valid = r_period_valid;
  assign dir_flip     = r_dir_flip;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: directed vector table, multi-cycle corner
// sequences and randomized pulse trains against a cycle-arithmetic model.
module tb_step_dir_decoder;

  localparam int MIN_PULSE = 4;
  localparam int TIMEOUT   = 1000;
  localparam int PW        = 24;
  localparam int PERW      = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            step_in = 1'b0, dir_in = 1'b0, enable_n_in = 1'b0;
  logic            pos_clear = 1'b0, pos_load = 1'b0;
  logic [PW-1:0]   pos_load_val = '0;
  logic [PW-1:0]   position;
  logic            step_valid, step_dir, period_valid, moving, stall, dir_flip;
  logic [PERW-1:0] period;
  logic [1:0]      dbg_state;

  step_dir_decoder #(
    .MIN_PULSE(MIN_PULSE), .TIMEOUT_CYCLES(TIMEOUT), .POS_WIDTH(PW), .PERIOD_WIDTH(PERW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_in(step_in), .dir_in(dir_in),
    .enable_n_in(enable_n_in), .pos_clear(pos_clear), .pos_load(pos_load),
    .pos_load_val(pos_load_val), .position(position), .step_valid(step_valid),
    .step_dir(step_dir), .period(period), .period_valid(period_valid),
    .moving(moving), .stall(stall), .dir_flip(dir_flip), .dbg_state(dbg_state)
  );

  // clock / cycle count
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog simulation exceeded time budget");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: expected step_valid cycles; capture of the last reported step
  logic [31:0]     exp_q[$];
  int              cap_cnt = 0, cap_cyc = 0, stall_cnt = 0, stall_cyc = 0;
  logic [PW-1:0]   cap_pos;
  logic            cap_dir, cap_flip, cap_pv;
  logic [PERW-1:0] cap_per;

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && int'(exp_q[0]) < cyc) begin
        checks++; errors++;
        $display("FAIL step_missing no step_valid at cycle %0d, now %0d", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (step_valid) begin
        cap_cnt++; cap_cyc = cyc;
        cap_pos = position; cap_dir = step_dir; cap_flip = dir_flip;
        cap_pv = period_valid; cap_per = period;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_unexpected step_valid=1 at cycle %0d, expected none", cyc);
        end else begin
          check("step_timing", 32'(cyc), exp_q.pop_front());
        end
      end else if (period_valid) begin
        checks++; errors++;
        $display("FAIL pv_alone period_valid=1 without step_valid at cycle %0d", cyc);
      end
      if (stall) begin
        stall_cnt++; stall_cyc = cyc;
      end
    end
  end

  // reference model: steps in terms of pulse rise times and plain arithmetic
  logic [PW-1:0]   m_pos = '0;
  logic            m_dir = 1'b0, m_have = 1'b0, m_moving = 1'b0, m_en = 1'b1;
  logic            m_flip = 1'b0, m_pv = 1'b0;
  logic [PERW-1:0] m_per = '0;
  int              m_last = 0, m_cnt = 0;

  task automatic model_step(input int vcyc, input logic d, input int strb, input logic [PW-1:0] ldv);
    int diff;
    diff   = vcyc - m_last;
    m_pv   = m_moving && (diff - 1 <= TIMEOUT);
    if (m_pv) m_per = (diff > 65535) ? 16'hFFFF : PERW'(diff);
    m_flip = m_have && (d != m_dir);
    m_dir  = d; m_have = 1'b1; m_moving = 1'b1; m_last = vcyc; m_cnt++;
    if (strb == 1 || strb == 3) m_pos = '0;
    else if (strb == 2)         m_pos = ldv;
    else                        m_pos = d ? m_pos - PW'(1) : m_pos + PW'(1);
  endtask

  // driver: called at a negedge; strobe (1 clear, 2 load, 3 both) lands on the step_valid edge
  task automatic pulse(input int hi, input int lo, input logic d, input int strb, input logic [PW-1:0] ldv);
    int n;
    n = cyc;
    dir_in = d; step_in = 1'b1;
    if (m_en && hi >= MIN_PULSE) begin
      exp_q.push_back(32'(n + MIN_PULSE + 4));
      model_step(n + MIN_PULSE + 4, d, strb, ldv);
    end
    for (int k = 1; k <= hi; k++) begin
      @(negedge clk);
      if (k == 7 && strb != 0) begin
        pos_clear = (strb == 1 || strb == 3);
        pos_load  = (strb >= 2);
        pos_load_val = ldv;
      end
      if (k == 8) begin
        pos_clear = 1'b0; pos_load = 1'b0;
      end
    end
    step_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic strobe(input int kind, input logic [PW-1:0] v);
    if (kind == 1) pos_clear = 1'b1;
    else begin pos_load = 1'b1; pos_load_val = v; end
    @(negedge clk);
    pos_clear = 1'b0; pos_load = 1'b0;
    m_pos = (kind == 1) ? '0 : v;
  endtask

  task automatic check_model();
    check("mdl_count", 32'(cap_cnt), 32'(m_cnt));
    check("mdl_pos", 32'(cap_pos), 32'(m_pos));
    check("mdl_dir", 32'(cap_dir), 32'(m_dir));
    check("mdl_flip", 32'(cap_flip), 32'(m_flip));
    check("mdl_pv", 32'(cap_pv), 32'(m_pv));
    if (m_pv) check("mdl_period", 32'(cap_per), 32'(m_per));
  endtask

  typedef struct {
    int hi; int lo; logic d; int strb; logic [PW-1:0] ldv;
    logic [PW-1:0] e_pos; logic e_flip; logic e_pv; logic [PERW-1:0] e_per;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int n0, s0, hi, lo;
    logic d;
    tbl[0]  = '{20, 380, 1'b0, 0, 24'h0,      24'd1,      1'b0, 1'b0, 16'd0};
    tbl[1]  = '{20, 380, 1'b0, 0, 24'h0,      24'd2,      1'b0, 1'b1, 16'd400};
    tbl[2]  = '{20, 380, 1'b0, 0, 24'h0,      24'd3,      1'b0, 1'b1, 16'd400};
    tbl[3]  = '{20, 380, 1'b0, 0, 24'h0,      24'd4,      1'b0, 1'b1, 16'd400};
    tbl[4]  = '{20, 380, 1'b0, 0, 24'h0,      24'd5,      1'b0, 1'b1, 16'd400};
    tbl[5]  = '{20, 100, 1'b1, 0, 24'h0,      24'd4,      1'b1, 1'b1, 16'd400};
    tbl[6]  = '{20, 100, 1'b1, 0, 24'h0,      24'd3,      1'b0, 1'b1, 16'd120};
    tbl[7]  = '{12, 100, 1'b1, 1, 24'h0,      24'd0,      1'b0, 1'b1, 16'd120};
    tbl[8]  = '{12, 100, 1'b1, 0, 24'h0,      24'hFFFFFF, 1'b0, 1'b1, 16'd112};
    tbl[9]  = '{12, 100, 1'b0, 2, 24'h7FFFFF, 24'h7FFFFF, 1'b1, 1'b1, 16'd112};
    tbl[10] = '{12, 100, 1'b0, 0, 24'h0,      24'h800000, 1'b0, 1'b1, 16'd112};

    // reset
    repeat (3) @(negedge clk);
    check("rst_position", 32'(position), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_flags", 32'({step_valid, step_dir, period_valid, moving, stall, dir_flip}), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_position", 32'(position), 32'd0);
    check("post_rst_moving", 32'(moving), 32'd0);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      n0 = cap_cnt;
      pulse(tbl[i].hi, tbl[i].lo, tbl[i].d, tbl[i].strb, tbl[i].ldv);
      check($sformatf("tbl%0d_count", i), 32'(cap_cnt - n0), 32'd1);
      check($sformatf("tbl%0d_pos", i), 32'(cap_pos), 32'(tbl[i].e_pos));
      check($sformatf("tbl%0d_flip", i), 32'(cap_flip), 32'(tbl[i].e_flip));
      check($sformatf("tbl%0d_pv", i), 32'(cap_pv), 32'(tbl[i].e_pv));
      if (tbl[i].e_pv) check($sformatf("tbl%0d_period", i), 32'(cap_per), 32'(tbl[i].e_per));
      check_model();
      if (i == 4) check("tbl_moving", 32'(moving), 32'd1);
    end

    // short glitches are ignored
    n0 = cap_cnt;
    repeat (3) pulse(3, 20, 1'b0, 0, '0);
    check("glitch_count", 32'(cap_cnt - n0), 32'd0);
    check("glitch_pos", 32'(position), 32'(m_pos));

    // stall after the step train stops
    pulse(20, 50, 1'b0, 0, '0);
    check_model();
    check("pre_stall_moving", 32'(moving), 32'd1);
    s0 = stall_cnt;
    repeat (1100) @(negedge clk);
    check("stall_count", 32'(stall_cnt - s0), 32'd1);
    check("stall_cycle", 32'(stall_cyc), 32'(cap_cyc + TIMEOUT));
    check("stall_moving", 32'(moving), 32'd0);
    pulse(20, 50, 1'b1, 0, '0);
    check_model();

    // enable drops mid-pulse, then disabled pulses
    n0 = cap_cnt;
    dir_in = 1'b0; step_in = 1'b1;
    repeat (2) @(negedge clk);
    enable_n_in = 1'b1; m_en = 1'b0; m_have = 1'b0; m_moving = 1'b0;
    repeat (18) @(negedge clk);
    step_in = 1'b0;
    repeat (30) @(negedge clk);
    repeat (3) pulse(20, 30, 1'b0, 0, '0);
    check("disabled_count", 32'(cap_cnt - n0), 32'd0);
    check("disabled_pos", 32'(position), 32'(m_pos));
    check("disabled_moving", 32'(moving), 32'd0);

    // re-enable: first step reports neither period nor flip
    enable_n_in = 1'b0; m_en = 1'b1;
    repeat (10) @(negedge clk);
    pulse(20, 40, 1'b1, 0, '0);
    check_model();

    // randomized trains with occasional strobes
    for (int i = 0; i < 40; i++) begin
      hi = $urandom_range(5, 30);
      lo = $urandom_range(6, 60);
      d  = 1'($urandom_range(0, 1));
      pulse(hi, lo, d, 0, '0);
      check_model();
      if ($urandom_range(0, 4) == 0) begin
        strobe($urandom_range(1, 2), PW'($urandom));
        check("rand_strobe_pos", 32'(position), 32'(m_pos));
      end
    end

    // reset with step held high: no step until the line has been seen low
    step_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_pos", 32'(position), 32'd0);
    check("async_rst_moving", 32'(moving), 32'd0);
    exp_q.delete();
    m_pos = '0; m_have = 1'b0; m_moving = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = cap_cnt;
    repeat (30) @(negedge clk);
    check("rst_high_count", 32'(cap_cnt - n0), 32'd0);
    step_in = 1'b0;
    repeat (20) @(negedge clk);
    pulse(20, 40, 1'b0, 0, '0);
    check_model();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
